sentry_network_get_resp: RTL and testbench
==========================================

Name: sentry_network_get_resp

Overview:
- Downstream consumer of the sentry network buffer's GET completion outputs (net_get_done one-hot lane mask, net_get_data 64-bit word).
- Captures each completed network word into a small per-sentry-lane FIFO.
- Presents each lane to its sentry checking pipeline over a valid/ready handshake.
- Exports a credit signal so GET request issue stalls before any lane can overflow.

Parameters:
- SENTRY_WIDTH, `SENTRY_WIDTH (4): number of sentry lanes; width of net_get_done.
- X_LEN, `X_LEN (64): data word width.
- LANE_DEPTH, 4: entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
- net_get_done  in  SENTRY_WIDTH  one-cycle lane mask from the network buffer; each set bit means net_get_data is valid for that lane this cycle.
- net_get_data  in  X_LEN  GET data word; qualified by net_get_done.
- resp_valid  out  SENTRY_WIDTH  per-lane: lane FIFO is non-empty.
- resp_ready  in  SENTRY_WIDTH  per-lane consumer accept.
- resp_data  out  SENTRY_WIDTH*X_LEN  per-lane head word; lane i occupies bits [i*X_LEN +: X_LEN].
- lane_full  out  SENTRY_WIDTH  per-lane: count == LANE_DEPTH.
- get_credit_ok  out  1  high when every lane count <= LANE_DEPTH-1; drives the GET request issue gate.
- ovf_err  out  SENTRY_WIDTH  sticky per-lane overflow flag.
- ovf_clr  in  1  synchronous clear of all ovf_err bits.
- delivered_cnt  out  32  total accepted handshakes across all lanes; wraps modulo 2^32.

Behaviour:
- Reset (rst low, async):
  - All lane wr_ptr, rd_ptr and count go to 0.
  - Outputs go to: resp_valid 0, lane_full 0, get_credit_ok 1, ovf_err 0, delivered_cnt 0.
  - resp_data is 0 while empty; storage is not reset.
- Push:
  - Lane i pushes on any cycle with net_get_done[i]=1.
  - A multi-bit mask writes the same word into every flagged lane in the same cycle.
  - A mask of 0 is a no-op.
- Pop:
  - Lane i pops when resp_valid[i] && resp_ready[i].
  - resp_ready with resp_valid low is ignored.
- Latency and ordering:
  - Show-ahead FIFO: a word pushed into an empty lane at edge N is visible on resp_data/resp_valid after edge N (zero bubble).
  - Per-lane order is FIFO; there is no ordering between lanes.
- Pointers:
  - log2(LANE_DEPTH) bits, natural wrap.
  - count is log2(LANE_DEPTH)+1 bits; new count = count + push - pop.
- Simultaneous push and pop:
  - Count unchanged; head advances; the new word is written at wr_ptr.
  - Holds when full: the push is accepted, no overflow.
  - Holds when count == 1: the next head is the new word on the following cycle.
- Overflow:
  - Condition: push with count == LANE_DEPTH and no pop.
  - The word is dropped; pointers and count are unchanged; ovf_err[i] is set.
- ovf_err priority: ovf_clr and a new overflow in the same cycle leave the bit set (set wins).
- Flags:
  - lane_full and get_credit_ok are combinational from registered counts.
  - get_credit_ok also goes low when any lane is full.
- delivered_cnt adds popcount of pops each cycle, so up to SENTRY_WIDTH per cycle.
- resp_data for an empty lane is 0, not stale data.
- Reset mid-operation: all buffered words are discarded immediately. In-flight net_get_done pulses during reset are ignored.

Test Plan:
- Single lane fill/drain:
  - Stimulus: done=4'b0001 with data 0xA0..0xA3 on 4 consecutive cycles, resp_ready=0; then resp_ready[0]=1.
  - Required: lane_full[0]=1 and get_credit_ok=0 after the 4th push; resp_data lane0 reads 0xA0, 0xA1, 0xA2, 0xA3 on successive cycles; delivered_cnt=4; resp_valid[0]=0 afterwards.
- Overflow:
  - Stimulus: lane 2 full; push 0xBEEF with resp_ready[2]=0.
  - Required: ovf_err[2]=1; contents unchanged (head still the first word); ovf_clr clears the flag next cycle.
- Full with simultaneous push and pop:
  - Stimulus: lane 1 full of 0x10..0x13; push 0x14 with resp_ready[1]=1.
  - Required: no ovf_err; count stays 4; drain order 0x11, 0x12, 0x13, 0x14.
- Broadcast and concurrency:
  - Stimulus: done=4'b1111 with data 0x55, all resp_ready=1.
  - Required: all resp_valid high for one cycle with data 0x55; delivered_cnt increments by 4 in one cycle.
- Wrap-around:
  - Stimulus: 10 push/pop pairs on lane 3 with data 0..9, ready held high.
  - Required: outputs 0..9 in order with one-entry occupancy; pointers wrap twice with no corruption.
- Async reset mid-traffic:
  - Stimulus: rst low between clock edges while lanes hold 2 words.
  - Required: resp_valid=0, get_credit_ok=1, delivered_cnt=0 immediately; a done pulse while rst is low produces no entry.

Source files
------------

// File: rtl/sentry_network_get_resp.sv
// Sentry network GET response buffer.
// Captures completed network GET words into per-lane show-ahead FIFOs and
// presents each lane to its sentry checking pipeline over valid/ready.
// A credit output stalls GET issue while any lane is full.
module sentry_network_get_resp #(
  parameter int unsigned SENTRY_WIDTH = 4,
  parameter int unsigned X_LEN        = 64,
  parameter int unsigned LANE_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SENTRY_WIDTH-1:0]        net_get_done,
  input  logic [X_LEN-1:0]               net_get_data,
  output logic [SENTRY_WIDTH-1:0]        resp_valid,
  input  logic [SENTRY_WIDTH-1:0]        resp_ready,
  output logic [SENTRY_WIDTH*X_LEN-1:0]  resp_data,
  output logic [SENTRY_WIDTH-1:0]        lane_full,
  output logic                           get_credit_ok,
  output logic [SENTRY_WIDTH-1:0]        ovf_err,
  input  logic                           ovf_clr,
  output logic [31:0]                    delivered_cnt
);

  localparam int unsigned PtrW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(LANE_DEPTH);

  logic [X_LEN-1:0] mem_q [SENTRY_WIDTH][LANE_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q [SENTRY_WIDTH];
  logic [PtrW-1:0]  rd_ptr_q [SENTRY_WIDTH];
  logic [CntW-1:0]  count_q  [SENTRY_WIDTH];
  logic [CntW-1:0]  count_d  [SENTRY_WIDTH];

  logic [SENTRY_WIDTH-1:0] pop;
  logic [SENTRY_WIDTH-1:0] wr_en;
  logic [SENTRY_WIDTH-1:0] ovf_set;
  logic [SENTRY_WIDTH-1:0] ovf_q;
  logic [SENTRY_WIDTH-1:0] ovf_d;
  logic [31:0]             pop_cnt;
  logic [31:0]             delivered_q;

  // Per-lane handshake decode, flags and head-word presentation.
  always_comb begin
    resp_valid = '0;
    lane_full  = '0;
    pop        = '0;
    wr_en      = '0;
    ovf_set    = '0;
    resp_data  = '0;
    pop_cnt    = '0;
    for (int unsigned i = 0; i < SENTRY_WIDTH; i++) begin
      resp_valid[i] = (count_q[i] != '0);
      lane_full[i]  = (count_q[i] == FullCnt);
      pop[i]        = resp_valid[i] & resp_ready[i];
      // A push into a full lane is only accepted when the head leaves this cycle.
      wr_en[i]      = net_get_done[i] & (~lane_full[i] | pop[i]);
      ovf_set[i]    = net_get_done[i] & lane_full[i] & ~pop[i];
      count_d[i]    = count_q[i] + CntW'(wr_en[i]) - CntW'(pop[i]);
      // Empty lanes show zero rather than stale storage.
      if (resp_valid[i]) begin
        resp_data[i*X_LEN +: X_LEN] = mem_q[i][rd_ptr_q[i]];
      end
      pop_cnt = pop_cnt + 32'(pop[i]);
    end
    ovf_d         = (ovf_q & ~{SENTRY_WIDTH{ovf_clr}}) | ovf_set;
    get_credit_ok = ~|lane_full;
  end

  // Lane storage; deliberately not reset since empty lanes mask it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < SENTRY_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= net_get_data;
      end
    end
  end

  // Pointer, count, overflow and delivery counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SENTRY_WIDTH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q       <= '0;
      delivered_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SENTRY_WIDTH; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_d[i];
      end
      ovf_q       <= ovf_d;
      delivered_q <= delivered_q + pop_cnt;
    end
  end

  assign ovf_err       = ovf_q;
  assign delivered_cnt = delivered_q;

endmodule

// File: tb/tb_sentry_network_get_resp.sv
// Scoreboard bench for sentry_network_get_resp: per-lane expected queues are
// filled as GET words are driven and drained/compared as the lanes hand off.
module tb_sentry_network_get_resp;

  localparam int W = 4;
  localparam int XL = 64;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [W-1:0]    net_get_done = '0;
  logic [XL-1:0]   net_get_data = '0;
  logic [W-1:0]    resp_valid;
  logic [W-1:0]    resp_ready = '0;
  logic [W*XL-1:0] resp_data;
  logic [W-1:0]    lane_full;
  logic            get_credit_ok;
  logic [W-1:0]    ovf_err;
  logic            ovf_clr = 1'b0;
  logic [31:0]     delivered_cnt;

  sentry_network_get_resp #(
    .SENTRY_WIDTH(W),
    .X_LEN       (XL),
    .LANE_DEPTH  (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .net_get_done (net_get_done),
    .net_get_data (net_get_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .lane_full    (lane_full),
    .get_credit_ok(get_credit_ok),
    .ovf_err      (ovf_err),
    .ovf_clr      (ovf_clr),
    .delivered_cnt(delivered_cnt)
  );

  always #5 clk = ~clk;

  logic [XL-1:0] exp_q [W][$];
  logic [W-1:0]  exp_ovf = '0;
  logic [31:0]   exp_del = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every observable output against the queue model.
  task automatic check_outputs();
    logic any_full;
    any_full = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("valid%0d", i), 64'(resp_valid[i]), 64'(exp_q[i].size() != 0));
      check($sformatf("full%0d", i), 64'(lane_full[i]), 64'(exp_q[i].size() == D));
      check($sformatf("data%0d", i), resp_data[i*XL +: XL],
            (exp_q[i].size() != 0) ? exp_q[i][0] : 64'h0);
      if (exp_q[i].size() == D) any_full = 1'b1;
    end
    check("credit", 64'(get_credit_ok), 64'(!any_full));
    check("ovf", 64'(ovf_err), 64'(exp_ovf));
    check("delivered", 64'(delivered_cnt), 64'(exp_del));
  endtask

  // One clock: check, drive, advance the model across the edge.
  task automatic cycle(input logic [W-1:0] done, input logic [XL-1:0] data,
                       input logic [W-1:0] ready, input logic clr);
    logic [W-1:0] pop_m;
    logic [W-1:0] set_m;
    check_outputs();
    net_get_done = done;
    net_get_data = data;
    resp_ready   = ready;
    ovf_clr      = clr;
    pop_m = '0;
    set_m = '0;
    for (int i = 0; i < W; i++) begin
      pop_m[i] = ready[i] && (exp_q[i].size() != 0);
      if (done[i] && exp_q[i].size() == D && !pop_m[i]) set_m[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (pop_m[i]) begin
        void'(exp_q[i].pop_front());
        exp_del = exp_del + 32'd1;
      end
      if (done[i] && !set_m[i]) exp_q[i].push_back(data);
    end
    exp_ovf = (exp_ovf & ~{W{clr}}) | set_m;
    net_get_done = '0;
    resp_ready   = '0;
    ovf_clr      = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(resp_valid), 64'h0);
    check("rst_credit", 64'(get_credit_ok), 64'h1);
    rst = 1'b1;

    // Single lane fill then drain.
    for (int k = 0; k < 4; k++) cycle(4'b0001, 64'hA0 + 64'(k), 4'b0000, 1'b0);
    check("fill_full0", 64'(lane_full[0]), 64'h1);
    check("fill_credit", 64'(get_credit_ok), 64'h0);
    for (int k = 0; k < 4; k++) begin
      check("drain_word", resp_data[0 +: XL], 64'hA0 + 64'(k));
      cycle(4'b0000, 64'h0, 4'b0001, 1'b0);
    end
    check("drain_cnt", 64'(delivered_cnt), 64'h4);
    check("drain_empty", 64'(resp_valid[0]), 64'h0);

    // Overflow on lane 2, including clear colliding with a fresh overflow.
    for (int k = 0; k < 4; k++) cycle(4'b0100, 64'h20 + 64'(k), 4'b0000, 1'b0);
    cycle(4'b0100, 64'hBEEF, 4'b0000, 1'b0);
    check("ovf_set", 64'(ovf_err[2]), 64'h1);
    check("ovf_head", resp_data[2*XL +: XL], 64'h20);
    cycle(4'b0100, 64'hBEEF, 4'b0000, 1'b1);
    check("ovf_set_wins", 64'(ovf_err[2]), 64'h1);
    cycle(4'b0000, 64'h0, 4'b0000, 1'b1);
    check("ovf_clr", 64'(ovf_err[2]), 64'h0);
    for (int k = 0; k < 4; k++) cycle(4'b0000, 64'h0, 4'b0100, 1'b0);

    // Full lane 1 with simultaneous push and pop.
    for (int k = 0; k < 4; k++) cycle(4'b0010, 64'h10 + 64'(k), 4'b0000, 1'b0);
    cycle(4'b0010, 64'h14, 4'b0010, 1'b0);
    check("pp_full", 64'(lane_full[1]), 64'h1);
    check("pp_noovf", 64'(ovf_err[1]), 64'h0);
    for (int k = 0; k < 4; k++) begin
      check("pp_order", resp_data[XL +: XL], 64'h11 + 64'(k));
      cycle(4'b0000, 64'h0, 4'b0010, 1'b0);
    end

    // Broadcast to all lanes, all consumed in one cycle.
    cycle(4'b1111, 64'h55, 4'b1111, 1'b0);
    check("bc_valid", 64'(resp_valid), 64'hF);
    cycle(4'b0000, 64'h0, 4'b1111, 1'b0);
    check("bc_cnt", 64'(delivered_cnt), 64'(exp_del));

    // Wrap-around on lane 3 with one-entry occupancy.
    cycle(4'b1000, 64'h0, 4'b0000, 1'b0);
    for (int k = 1; k < 10; k++) cycle(4'b1000, 64'(k), 4'b1000, 1'b0);
    check("wrap_last", resp_data[3*XL +: XL], 64'h9);
    cycle(4'b0000, 64'h0, 4'b1000, 1'b0);

    // Async reset mid-traffic with two words in lanes 0 and 1.
    for (int k = 0; k < 2; k++) cycle(4'b0011, 64'h70 + 64'(k), 4'b0000, 1'b0);
    check_outputs();
    #2;
    rst = 1'b0;
    net_get_done = 4'b0001;
    net_get_data = 64'hDEAD;
    #1;
    check("ar_valid", 64'(resp_valid), 64'h0);
    check("ar_credit", 64'(get_credit_ok), 64'h1);
    check("ar_cnt", 64'(delivered_cnt), 64'h0);
    @(posedge clk);
    #1;
    net_get_done = '0;
    rst = 1'b1;
    for (int i = 0; i < W; i++) exp_q[i].delete();
    exp_del = '0;
    exp_ovf = '0;
    cycle(4'b0000, 64'h0, 4'b0000, 1'b0);
    check("ar_noentry", 64'(resp_valid[0]), 64'h0);
    cycle(4'b0100, 64'h99, 4'b0000, 1'b0);
    cycle(4'b0000, 64'h0, 4'b0100, 1'b0);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
